// File: rtl/ball_renderer_pkg.sv
// Shared constants, state type and position-step helper for ball_renderer.
package ball_renderer_pkg;

  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;

  typedef enum logic {
    UNSYNCED,
    SYNCED
  } state_e;

  // One clamped move along an axis; 11-bit math keeps both ends from wrapping.
  function automatic logic [9:0] step(
    input logic [9:0]  p,
    input logic        dir,
    input logic [10:0] spd,
    input logic [10:0] lim
  );
    logic [10:0] s;
    if (dir) begin
      s = {1'b0, p} + spd;
      if (s > lim) s = lim;
    end else begin
      s = ({1'b0, p} < spd) ? 11'd0 : {1'b0, p} - spd;
    end
    return s[9:0];
  endfunction

endpackage

// File: rtl/ball_renderer_scan_counter.sv
// Pixel / line counters derived from the VGA timing strobes.
// hcount tracks the visible column, vcount the line since frame start.
module ball_renderer_scan_counter (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_HBlank,
  input  logic       i_VReset,
  output logic [9:0] o_HCount,
  output logic [9:0] o_VCount
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_HReset)
      h_d = '0;
    else if (!i_HBlank)
      h_d = h_q + 10'd1;
    if (i_VReset)
      v_d = '0;
    else if (i_HReset && v_q != 10'h3FF)
      v_d = v_q + 10'd1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_HCount = h_q;
  assign o_VCount = v_q;

endmodule

// File: rtl/ball_renderer.sv
// Ball position, per-frame bounce movement and pixel generation.
// Position only moves on frame start, so the drawn square never tears.
module ball_renderer
  import ball_renderer_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int SPEED     = 1,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_HBlank,
  input  logic       i_VReset,
  input  logic       i_VBlank,
  input  logic       i_XDir,
  input  logic       i_YDir,
  output logic       o_Ball,
  output logic [9:0] o_BallX,
  output logic [9:0] o_BallY,
  output logic       o_FrameTick
);

  localparam logic [10:0] SPD  = 11'(SPEED);
  localparam logic [10:0] SZ   = 11'(BALL_SIZE);
  localparam logic [10:0] XLIM = 11'(H_VISIBLE_AREA - BALL_SIZE);
  localparam logic [10:0] YLIM = 11'(V_VISIBLE_AREA - BALL_SIZE);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick_q, tick_d;
  logic [9:0] hcount, vcount;
  logic [10:0] hc, vc, bx, by;
  logic       in_x, in_y;

  ball_renderer_scan_counter u_scan (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_HReset (i_HReset),
    .i_HBlank (i_HBlank),
    .i_VReset (i_VReset),
    .o_HCount (hcount),
    .o_VCount (vcount)
  );

  // Every frame pulse moves the ball, including the one that syncs us.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tick_d  = 1'b0;
    if (i_VReset) begin
      state_d = SYNCED;
      x_d     = step(x_q, i_XDir, SPD, XLIM);
      y_d     = step(y_q, i_YDir, SPD, YLIM);
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= UNSYNCED;
      x_q     <= 10'(INIT_X);
      y_q     <= 10'(INIT_Y);
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tick_q  <= tick_d;
    end
  end

  assign hc   = {1'b0, hcount};
  assign vc   = {1'b0, vcount};
  assign bx   = {1'b0, x_q};
  assign by   = {1'b0, y_q};
  assign in_x = (hc >= bx) && (hc < bx + SZ);
  assign in_y = (vc >= by) && (vc < by + SZ);

  assign o_Ball = (state_q == SYNCED) && !i_HBlank && !i_VBlank
                && in_x && in_y;
  assign o_BallX     = x_q;
  assign o_BallY     = y_q;
  assign o_FrameTick = tick_q;

endmodule
